logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit for the datapath ALU slice. It applies one of eight bitwise operations to two WIDTH-bit source operands and captures the result, with optional flags, into a two-entry output buffer. The buffer is governed by valid/ready handshakes on both sides. It sits between the register-file read stage and the write-back arbiter, and it replaces the fixed 32-bit OR-only path with a registered, back-pressure-aware unit.

---
 rtl/logic_unit_pkg.sv | 26 ++
 rtl/logic_unit_core.sv | 32 +++
 rtl/logic_unit_pipe.sv | 133 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the bitwise logic unit.
// Optional feature macro: LOGIC_UNIT_FLAGS_EN (per-entry zero/parity flags).
package logic_unit_pkg;

    // Operation select encodings
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,   // s1 & ~s2
        OP_PASS = 3'd7    // s1
    } op_e;

    // Output buffer occupancy
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational op decode with enable gating; no state.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] s1_i,
    input  logic [WIDTH-1:0] s2_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] f;

    // Select the operation, then force zero when the unit is disabled
    always_comb begin
        f = '0;
        case (op_e'(op_i))
            OP_AND:  f = s1_i & s2_i;
            OP_OR:   f = s1_i | s2_i;
            OP_XOR:  f = s1_i ^ s2_i;
            OP_NOR:  f = ~(s1_i | s2_i);
            OP_NAND: f = ~(s1_i & s2_i);
            OP_XNOR: f = ~(s1_i ^ s2_i);
            OP_ANDN: f = s1_i & ~s2_i;
            default: f = s1_i;   // OP_PASS
        endcase
        result_o = enable_i ? f : '0;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: combinational core feeding a two-entry output
// buffer with valid/ready on both sides. Head entry drives reg_d/flags.
// Optional feature macro: LOGIC_UNIT_FLAGS_EN stores zero/parity flags per
// entry; without it out_zero/out_parity are tied low.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             enable,
    input  logic [WIDTH-1:0] reg_s1,
    input  logic [WIDTH-1:0] reg_s2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] reg_d,
    output logic             out_zero,
    output logic             out_parity
);

    logic [WIDTH-1:0] result;
    cnt_e             cnt_q, cnt_d;
    logic             push, pop;
    logic             head_we, tail_we, head_from_new;
    logic [WIDTH-1:0] head_q, head_d, tail_q;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op),
        .enable_i (enable),
        .s1_i     (reg_s1),
        .s2_i     (reg_s2),
        .result_o (result)
    );

    // in_ready looks only at registered occupancy and rst, never out_ready
    assign in_ready  = !rst && (cnt_q != FULL);
    assign out_valid = (cnt_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= EMPTY;
        else     cnt_q <= cnt_d;
    end

    // Next occupancy and entry write controls
    always_comb begin
        cnt_d         = cnt_q;
        head_we       = 1'b0;
        tail_we       = 1'b0;
        head_from_new = 1'b1;
        case (cnt_q)
            EMPTY: begin
                if (push) begin
                    cnt_d   = ONE;
                    head_we = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_we = 1'b1;          // new beat replaces departing head
                end else if (push) begin
                    cnt_d   = FULL;
                    tail_we = 1'b1;
                end else if (pop) begin
                    cnt_d   = EMPTY;         // head keeps its stale value
                end
            end
            FULL: begin
                if (pop) begin
                    cnt_d         = ONE;
                    head_we       = 1'b1;
                    head_from_new = 1'b0;    // promote second entry
                end
            end
            default: cnt_d = EMPTY;
        endcase
    end

    assign head_d = head_from_new ? result : tail_q;

    // Data storage for head and second entry
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (head_we) head_q <= head_d;
            if (tail_we) tail_q <= result;
        end
    end

    assign reg_d = head_q;

`ifdef LOGIC_UNIT_FLAGS_EN
    logic hz_q, hp_q, tz_q, tp_q;
    logic new_z, new_p;

    assign new_z = (result == '0);
    assign new_p = ^result;

    // Flag storage follows the data entries exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            hz_q <= 1'b0;
            hp_q <= 1'b0;
            tz_q <= 1'b0;
            tp_q <= 1'b0;
        end else begin
            if (head_we) begin
                hz_q <= head_from_new ? new_z : tz_q;
                hp_q <= head_from_new ? new_p : tp_q;
            end
            if (tail_we) begin
                tz_q <= new_z;
                tp_q <= new_p;
            end
        end
    end

    assign out_zero   = hz_q;
    assign out_parity = hp_q;
`else
    assign out_zero   = 1'b0;
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: accepted beats push an expected
// entry, a negedge monitor compares the head whenever out_valid is shown.
module tb_logic_unit_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic         enable = 1'b1;
    logic [W-1:0] reg_s1 = '0;
    logic [W-1:0] reg_s2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] reg_d;
    logic         out_zero;
    logic         out_parity;

    typedef struct {
        logic [W-1:0] d;
        logic         z;
        logic         p;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rst_edge = 1'b0;
    bit   rand_rdy = 1'b0;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .enable     (enable),
        .reg_s1     (reg_s1),
        .reg_s2     (reg_s2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .reg_d      (reg_d),
        .out_zero   (out_zero),
        .out_parity (out_parity)
    );

    always #5 clk = ~clk;

    // Reference: the op table applied with plain operators, then gated
    function automatic logic [W-1:0] ref_fn(int o, bit en, logic [W-1:0] a, logic [W-1:0] b);
        if (!en) return '0;
        case (o)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a | b);
            4: return ~(a & b);
            5: return ~(a ^ b);
            6: return a & ~b;
            default: return a;
        endcase
    endfunction

    function automatic exp_t mk(logic [W-1:0] d);
        exp_t e;
        e.d = d;
`ifdef LOGIC_UNIT_FLAGS_EN
        e.z = (d == '0);
        e.p = ^d;
`else
        e.z = 1'b0;
        e.p = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model reset: a sampled rst discards everything buffered
    always @(posedge clk) begin
        rst_edge = rst;
        if (rst) sb.delete();
    end

    // Monitor: handshake status against model occupancy, head against scoreboard
    always @(negedge clk) begin
        chk("in_ready", in_ready, (!rst && sb.size() < 2));
        chk("out_valid", out_valid, (sb.size() != 0));
        if (rst_edge) begin
            chk("rst_reg_d", reg_d, '0);
            chk("rst_zero", out_zero, '0);
            chk("rst_parity", out_parity, '0);
        end else if (sb.size() != 0) begin
            chk("reg_d", reg_d, sb[0].d);
            chk("out_zero", out_zero, sb[0].z);
            chk("out_parity", out_parity, sb[0].p);
            if (out_ready) void'(sb.pop_front());
        end
    end

    // Random back-pressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one beat until accepted; record its expected result on acceptance
    task automatic send(logic [2:0] o, bit en, logic [W-1:0] a, logic [W-1:0] b, exp_t e);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        op = o; enable = en; reg_s1 = a; reg_s2 = b; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = in_valid && in_ready;
            @(posedge clk);
            if (done) sb.push_back(e);
            #1;
            if (!done) begin
                t++;
                if (t > 200) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_rand();
        logic [2:0]   o;
        bit           en;
        logic [W-1:0] a, b;
        o  = 3'($urandom_range(0, 7));
        en = ($urandom_range(0, 7) != 0);
        a  = $urandom;
        b  = $urandom;
        send(o, en, a, b, mk(ref_fn(int'(o), en, a, b)));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] tbl [8];
        int           w;
        tbl[0] = 32'h00F0_1234; tbl[1] = 32'hFFF0_FFFF;
        tbl[2] = 32'hFF00_EDCB; tbl[3] = 32'h000F_0000;
        tbl[4] = 32'hFF0F_EDCB; tbl[5] = 32'h00FF_1234;
        tbl[6] = 32'hF000_0000; tbl[7] = 32'hF0F0_1234;

        // Reset held two cycles with a beat offered
        rst = 1'b1; in_valid = 1'b1; op = 3'd1;
        reg_s1 = $urandom; reg_s2 = $urandom;
        tick(2);
        rst = 1'b0; in_valid = 1'b0;
        tick(1);

        // All ops back-to-back, downstream always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send(3'(i), 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, mk(tbl[i]));
        // Enable gating
        send(3'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0));
        in_valid = 1'b0;
        tick(3);

        // Back-pressure: A and B absorbed, C stalls until release
        out_ready = 1'b0;
        send(3'd2, 1'b1, 32'hAAAA_0001, 32'h5555_0001, mk(32'hFFFF_0000));
        send(3'd0, 1'b1, 32'hBBBB_0002, 32'h0F0F_FFFF, mk(32'h0B0B_0002));
        fork
            send(3'd7, 1'b1, 32'hCCCC_0003, 32'h1234_5678, mk(32'hCCCC_0003));
            begin
                tick(4);
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        tick(4);

        // Continuous flow holding occupancy at one
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_rand();
        in_valid = 1'b0;
        tick(3);

        // Reset with a full buffer and a beat on offer
        out_ready = 1'b0;
        send_rand();
        send_rand();
        rst = 1'b1; in_valid = 1'b1; reg_s1 = $urandom;
        tick(1);
        rst = 1'b0; in_valid = 1'b0;
        tick(1);
        out_ready = 1'b1;
        send_rand();
        in_valid = 1'b0;
        tick(3);

        // Randomised traffic with random back-pressure and input gaps
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick(1);
            end
            send_rand();
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            tick(1);
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
